// File: rtl/demux3_dispatch_pkg.sv
// Shared definitions for the BIP result dispatcher: destination selects and FSM encodings.
package demux3_dispatch_pkg;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_DROP = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // Valid vector bit order is {C,B,A}; a drop select maps to no valid at all.
    function automatic logic [2:0] sel_to_vld(input logic [1:0] sel);
        logic [2:0] v;
        v = 3'b000;
        case (sel)
            SEL_A:   v = 3'b001;
            SEL_B:   v = 3'b010;
            SEL_C:   v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/demux3_dispatch_fifo.sv
// Small synchronous FIFO with full/empty/count; push is ignored when full, pop when empty.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & !o_full;
    assign w_pop   = i_pop & !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr <= '0;
        end else if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux3_dispatch.sv
// Routes one tagged word to sink A, B or C through a small FIFO and a single holding register.
module demux3_dispatch
    import demux3_dispatch_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic             out_c_valid,
    input  logic             out_c_ready,
    output logic [CNTW-1:0]  drop_cnt,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);

    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic [WIDTH+1:0]  w_head;
    logic [1:0]        w_head_sel;
    logic [WIDTH-1:0]  w_head_data;
    logic              w_push;
    logic              w_pop;
    logic              w_hs;

    logic [0:0]        r_state;
    logic [2:0]        r_vld;
    logic [WIDTH-1:0]  r_data;
    logic [CNTW-1:0]   r_drop_cnt;

    // Ready depends on occupancy only, so a same-cycle pop never opens a slot for a push.
    assign in_ready = !w_full;
    assign w_push   = in_valid & !w_full;

    assign {w_head_sel, w_head_data} = w_head;

    // Only the ready of the destination currently holding a valid can complete a transfer.
    assign w_hs  = (r_state == ST_HOLD) & (|(r_vld & {out_c_ready, out_b_ready, out_a_ready}));
    assign w_pop = !w_empty & ((r_state == ST_IDLE) | w_hs);

    sync_fifo #(
        .WIDTH (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({in_sel, in_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_vld   <= '0;
            r_data  <= '0;
        end else if (w_pop) begin
            if (w_head_sel == SEL_DROP) begin
                r_state <= ST_IDLE;
                r_vld   <= '0;
            end else begin
                r_state <= ST_HOLD;
                r_vld   <= sel_to_vld(w_head_sel);
                r_data  <= w_head_data;
            end
        end else if (w_hs) begin
            r_state <= ST_IDLE;
            r_vld   <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_pop && (w_head_sel == SEL_DROP) && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNTW'(1);
        end
    end

    assign out_data    = r_data;
    assign out_a_valid = r_vld[0];
    assign out_b_valid = r_vld[1];
    assign out_c_valid = r_vld[2];
    assign drop_cnt    = r_drop_cnt;
    assign busy        = (w_count != '0) | (r_state == ST_HOLD);

endmodule
